mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: max consecutive granted cycles while the other master waits.
REQ-002 Parameter WAIT_W, default 16: width of the contention counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_req, m1_req  in  1  master bus request; held until the master's access completes.
REQ-006 m0_Addr, m1_Addr  in  32  master byte address.
REQ-007 m0_WriteData, m1_WriteData  in  32  master write data.
REQ-008 m0_MemRd, m1_MemRd, m0_MemWr, m1_MemWr  in  1  master read/write strobes.
REQ-009 m0_gnt, m1_gnt  out  1  registered grant, one-hot or zero.
REQ-010 m0_ReadData, m1_ReadData  out  32  read data returned to each master.
REQ-011 Addr, WriteData  out  32  shared memory/peripheral bus address and write data.
REQ-012 MemRd, MemWr  out  1  shared bus strobes.
REQ-013 ReadData  in  32  combinational read data from the shared memory/peripheral block.
REQ-014 wait_cnt  out  WAIT_W  saturating count of cycles in which some master requested without a grant.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0 and OWN1; m0_gnt=(state==OWN0) and m1_gnt=(state==OWN1).
REQ-016 IDLE: a single requester SHALL move the FSM to its OWN state at the next edge; with both requesting, it SHALL grant the master not flagged by last_served.
REQ-017 A grant SHALL appear exactly one cycle after req rises from IDLE: zero-wait arbitration is not permitted.
REQ-018 OWNx with req_x high SHALL stay in OWNx unless burst_cnt==BURST_MAX-1 and the other master requests; in that case it SHALL switch directly to the other OWN state.
REQ-019 OWNx with req_x low SHALL go to the other OWN state if that master requests, otherwise to IDLE; no idle bubble SHALL occur on handover.
REQ-020 burst_cnt SHALL clear on entering any state other than the current one, and SHALL increment each cycle spent in OWNx, saturating at BURST_MAX-1.
REQ-021 last_served SHALL update to x on every entry to OWNx.
REQ-022 The shared Addr and WriteData buses SHALL mux the granted master's signals combinationally, and SHALL be 0 when neither grant is high.
REQ-023 MemRd SHALL equal gnt_x & req_x & mx_MemRd, and MemWr likewise, so that a master dropping req in a granted cycle causes no bus access.
REQ-024 ReadData SHALL route combinationally to the granted master's ReadData; the non-granted master's ReadData SHALL be 0.
REQ-025 Read latency SHALL be zero cycles within the granted cycle; a write SHALL take effect at the edge ending the granted cycle.
REQ-026 wait_cnt SHALL increment when (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt), and SHALL saturate at all-ones.
REQ-027 A strobe asserted by a master without a grant SHALL be ignored; it SHALL NOT be queued.

Reset
REQ-028 Reset SHALL set state=IDLE, burst_cnt=0, last_served=1 (m0 wins the first conflict) and wait_cnt=0.
REQ-029 Reset asserted mid-burst SHALL drop both grants and the bus strobes from the next edge; the interrupted access SHALL NOT be retried.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/OWN0/OWN1), the BURST_MAX and WAIT_W defaults, and the 32-bit bus-width constant.
REQ-031 One sub-module, arb_rr_pick, SHALL implement the two-way round-robin choice from (req0, req1, last_served).
REQ-032 The bus mux and strobe gating SHALL stay in the top module.

Verification
REQ-033 Scenario: m0_req=1 only, m0_MemWr at Addr 0x10 with data 0xA5 -> m0_gnt=1 one cycle later, MemWr=1 for one cycle, word 0x10 written; wait_cnt=1.
REQ-034 Scenario: both masters request from IDLE right after reset -> OWN0 first; with both held, after 4 cycles the FSM switches to OWN1 for 4 cycles, then back to OWN0.
REQ-035 Scenario: m0 owns the bus and drops req while m1 requests -> the next cycle is OWN1 with no IDLE cycle; MemRd/MemWr are 0 in the cycle where m0_gnt=1 and m0_req=0.
REQ-036 Scenario: m1 reads Addr 0x40000008 while granted and ReadData=0x5 -> m1_ReadData=0x5 and m0_ReadData=0 in the same cycle.
REQ-037 Scenario: reset pulsed during an OWN1 burst -> both grants are 0 and MemWr=0 after the edge; the next conflict is granted to m0.
REQ-038 Scenario: m1 is held off for 70000 cycles with WAIT_W=16 -> wait_cnt saturates at 0xFFFF without wrapping.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int BUS_W         = 32;
  localparam int BURST_MAX_DEF = 4;
  localparam int WAIT_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic [BUS_W-1:0] bus_word_t;

  // One master's complete bus request, muxed as a unit onto the shared bus.
  typedef struct packed {
    logic      req;
    logic      rd;
    logic      wr;
    bus_word_t addr;
    bus_word_t wdata;
  } master_req_t;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-way round-robin choice: a lone requester wins, a conflict goes to the
// master that was not served last. Purely combinational.
module arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic pick_vld,
  output logic pick
);

  always_comb begin
    pick_vld = req0 | req1;
    if (req0 && req1) begin
      pick = ~last_served;
    end else begin
      pick = req1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a shared memory/peripheral bus with bounded bursts.
// Grants are registered one cycle after request; the bus mux and strobes are combinational.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int WAIT_W    = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [BUS_W-1:0]  m0_Addr,
  input  logic [BUS_W-1:0]  m1_Addr,
  input  logic [BUS_W-1:0]  m0_WriteData,
  input  logic [BUS_W-1:0]  m1_WriteData,
  input  logic              m0_MemRd,
  input  logic              m1_MemRd,
  input  logic              m0_MemWr,
  input  logic              m1_MemWr,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [BUS_W-1:0]  m0_ReadData,
  output logic [BUS_W-1:0]  m1_ReadData,
  output logic [BUS_W-1:0]  Addr,
  output logic [BUS_W-1:0]  WriteData,
  output logic              MemRd,
  output logic              MemWr,
  input  logic [BUS_W-1:0]  ReadData,
  output logic [WAIT_W-1:0] wait_cnt
);

  localparam int BC_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);

  arb_state_t      state;
  arb_state_t      state_nx;
  logic [BC_W-1:0] burst_cnt;
  logic            last_served;
  logic            pick_vld;
  logic            pick;
  master_req_t     mst0;
  master_req_t     mst1;
  master_req_t     sel;

  arb_rr_pick u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_served (last_served),
    .pick_vld    (pick_vld),
    .pick        (pick)
  );

  // Handover goes straight from one OWN state to the other, never via IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = own_state(pick);
        end
      end
      OWN0: begin
        if (m0_req) begin
          if (m1_req && burst_cnt == BURST_LAST) begin
            state_nx = OWN1;
          end
        end else begin
          state_nx = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          if (m0_req && burst_cnt == BURST_LAST) begin
            state_nx = OWN0;
          end
        end else begin
          state_nx = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      state  <= state_nx;
      m0_gnt <= (state_nx == OWN0);
      m1_gnt <= (state_nx == OWN1);
      if (state_nx != state) begin
        burst_cnt <= '0;
        if (state_nx == OWN0) begin
          last_served <= 1'b0;
        end else if (state_nx == OWN1) begin
          last_served <= 1'b1;
        end
      end else if (state != IDLE && burst_cnt != BURST_LAST) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (((m0_req & ~m0_gnt) | (m1_req & ~m1_gnt)) &&
                 wait_cnt != {WAIT_W{1'b1}}) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign mst0 = '{req: m0_req, rd: m0_MemRd, wr: m0_MemWr, addr: m0_Addr, wdata: m0_WriteData};
  assign mst1 = '{req: m1_req, rd: m1_MemRd, wr: m1_MemWr, addr: m1_Addr, wdata: m1_WriteData};

  // Strobes are gated by req so a master letting go mid-grant makes no access.
  always_comb begin
    sel = '0;
    if (m0_gnt) begin
      sel = mst0;
    end else if (m1_gnt) begin
      sel = mst1;
    end
    Addr      = sel.addr;
    WriteData = sel.wdata;
    MemRd     = sel.req & sel.rd;
    MemWr     = sel.req & sel.wr;
  end

  always_comb begin
    m0_ReadData = '0;
    m1_ReadData = '0;
    if (m0_gnt) begin
      m0_ReadData = ReadData;
    end else if (m1_gnt) begin
      m1_ReadData = ReadData;
    end
  end

  grant_onehot_a: assert property (@(posedge clk) !(m0_gnt && m1_gnt));

endmodule
